dma_axi_w: RTL
==============

Name: dma_axi_w

Overview:
- AXI4 write-burst master for the DMA engine; the write-direction counterpart of the DMA AXI read master.
- Accepts the native databus: one request whose first assertion starts a burst, then one beat per handshake.
- Issues a single INCR burst of dma_len+1 beats on AW/W, collects the B response and flags errors.
- Sits between the DMA controller/databus and the AXI interconnect write channels.

Parameters:
- DMA_DATA_WIDTH, 32, data bus width in bits (power of 2, at least 8).
- ADDR_W, `AXI_ADDR_W, address width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- valid  in  1  databus request; held high while beats are offered.
- addr  in  ADDR_W  burst start address; sampled in IDLE.
- wdata  in  DMA_DATA_WIDTH  beat data.
- wstrb  in  DMA_DATA_WIDTH/8  beat byte strobes.
- ready  out  1  beat accepted (combinational).
- dma_len  in  `AXI_LEN_W  beats minus 1; sampled in IDLE.
- dma_ready  out  1  idle, can accept a new burst.
- error  out  1  sticky-until-next-burst write-response error.
- m_axi_awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awqos  out  AXI widths  AW channel.
- m_axi_awvalid  out  1 and m_axi_awready  in  1  AW handshake.
- m_axi_wdata  out  DMA_DATA_WIDTH and m_axi_wstrb  out  DMA_DATA_WIDTH/8  W payload.
- m_axi_wlast  out  1; m_axi_wvalid  out  1; m_axi_wready  in  1  W channel.
- m_axi_bresp  in  `AXI_RESP_W; m_axi_bvalid  in  1; m_axi_bready  out  1  B channel.

Behaviour:
- Reset values: state=IDLE, dma_ready=1, error=0, awvalid=0, counter=0, addr_r=0, len_r=0. Combinational outputs wvalid, wlast, bready and ready are 0 at reset.
- AW constants: awid=0, awaddr=addr_r, awlen=len_r, awsize=$clog2(DMA_DATA_WIDTH/8), awburst=2'b01 (INCR), awlock=0, awcache=4'h2, awprot=3'b010, awqos=0.
- W payload: m_axi_wdata=wdata and m_axi_wstrb=wstrb, passthrough.
- IDLE:
  - dma_ready=1.
  - If valid: latch addr_r<=addr, len_r<=dma_len, counter<=0, error<=0, awvalid<=1, dma_ready<=0, go to ADDR.
  - No beat is consumed in IDLE (ready=0).
- ADDR:
  - awvalid held 1 (registered, never dependent on awready).
  - On awready: awvalid<=0, go to DATA. AW handshake occurs exactly once per burst.
- DATA:
  - wvalid=valid; wlast=(counter==len_r).
  - ready=valid&wready; a beat transfers when valid&wready.
  - Each transfer: counter<=counter+1.
  - Transfer with wlast=1: go to RESP.
  - valid low creates wait cycles; counter and state hold.
- RESP:
  - bready=1; wvalid=0, ready=0.
  - On bvalid: error<=(bresp!=2'b00), go to IDLE, dma_ready<=1 next cycle.
- Counter width `AXI_LEN_W. len_r=255 gives 256 beats; the counter is never compared after the wrap.
- Minimum latency, len=0, all slave ready signals high:
  - valid rises at cycle 0 (IDLE).
  - awvalid at cycle 1; beat at cycle 2.
  - bready with bvalid at cycle 3; dma_ready=1 at cycle 4.
- Simultaneous events:
  - bvalid arriving early, before RESP, is not acknowledged until RESP.
  - awready while awvalid=0 is ignored.
- Reset mid-burst aborts immediately to reset values; no beats or responses are generated afterwards.
- error holds until the next burst starts in IDLE.

Test Plan:
- Single beat: dma_len=0, addr=0x100, wdata=0xA5A5A5A5, slave always ready.
  - awaddr=0x100, awlen=0, one W beat with wlast=1, ready pulses once.
  - bresp=OKAY -> error=0, dma_ready=1 four cycles after valid.
- 4-beat burst: dma_len=3, wready low every other cycle, data 1..4.
  - Exactly 4 W transfers with data 1,2,3,4 in order.
  - wlast only on data 4; ready asserts only on transfer cycles.
- AW stall: awready held low 3 cycles.
  - awvalid stays 1 for those 3 cycles, no W beat before the AW handshake.
  - awaddr/awlen stable throughout.
- Response error: bresp=2'b10 (SLVERR) -> error=1 after return to IDLE.
  - A following burst with OKAY -> error=0.
- Source gaps: valid drops 2 cycles mid-burst (dma_len=2).
  - wvalid follows valid; counter holds; still exactly 3 beats, wlast on the third.
- Reset mid-burst: rst_n low during beat 2 of 4.
  - All outputs take reset values; dma_ready=1, awvalid=0, wvalid=0 after release.
  - A fresh burst completes normally.

Source files
------------

// File: rtl/dma_axi_w_if.sv
// AXI4 write-channel bundle (AW, W, B) between the DMA write master and the interconnect.
// The master modport is the DMA side; the slave modport is the interconnect side.
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif
`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif

interface dma_axi_w_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = `AXI_ADDR_W
);
    logic [`AXI_ID_W-1:0]   m_axi_awid;
    logic [ADDR_W-1:0]      m_axi_awaddr;
    logic [`AXI_LEN_W-1:0]  m_axi_awlen;
    logic [2:0]             m_axi_awsize;
    logic [1:0]             m_axi_awburst;
    logic                   m_axi_awlock;
    logic [3:0]             m_axi_awcache;
    logic [2:0]             m_axi_awprot;
    logic [3:0]             m_axi_awqos;
    logic                   m_axi_awvalid;
    logic                   m_axi_awready;
    logic [DATA_W-1:0]      m_axi_wdata;
    logic [DATA_W/8-1:0]    m_axi_wstrb;
    logic                   m_axi_wlast;
    logic                   m_axi_wvalid;
    logic                   m_axi_wready;
    logic [`AXI_RESP_W-1:0] m_axi_bresp;
    logic                   m_axi_bvalid;
    logic                   m_axi_bready;

    modport master (
        output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
               m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awvalid,
               m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid, m_axi_bready,
        input  m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid
    );

    modport slave (
        input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
               m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awvalid,
               m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid, m_axi_bready,
        output m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid
    );
endinterface

// File: rtl/dma_axi_w.sv
// AXI4 write-burst master: turns one databus request into a single INCR burst of
// dma_len+1 beats, then collects the B response and reports a sticky error flag.
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif
`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif

module dma_axi_w #(
    parameter int DMA_DATA_WIDTH = 32,
    parameter int ADDR_W         = `AXI_ADDR_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        valid,
    input  logic [ADDR_W-1:0]           addr,
    input  logic [DMA_DATA_WIDTH-1:0]   wdata,
    input  logic [DMA_DATA_WIDTH/8-1:0] wstrb,
    output logic                        ready,
    input  logic [`AXI_LEN_W-1:0]       dma_len,
    output logic                        dma_ready,
    output logic                        error,
    dma_axi_w_if.master                 axi
);
    localparam int         LEN_W  = `AXI_LEN_W;
    localparam int         STRB_W = DMA_DATA_WIDTH / 8;
    localparam logic [2:0] AXSIZE = 3'($clog2(STRB_W));

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [ADDR_W-1:0]  addr_r;
    logic [LEN_W-1:0]   len_r;
    logic [LEN_W-1:0]   counter_r;
    logic               error_r;
    logic               awvalid_r;
    logic               dma_ready_r;
    logic               wvalid_s;
    logic               wlast_s;
    logic               ready_s;
    logic               bready_s;

    // State register and burst bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            addr_r      <= {ADDR_W{1'b0}};
            len_r       <= {LEN_W{1'b0}};
            counter_r   <= {LEN_W{1'b0}};
            error_r     <= 1'b0;
            awvalid_r   <= 1'b0;
            dma_ready_r <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            case (state_r)
                ST_IDLE: begin
                    if (valid) begin
                        addr_r      <= addr;
                        len_r       <= dma_len;
                        counter_r   <= {LEN_W{1'b0}};
                        error_r     <= 1'b0;
                        awvalid_r   <= 1'b1;
                        dma_ready_r <= 1'b0;
                    end
                end
                ST_ADDR: begin
                    if (axi.m_axi_awready) begin
                        awvalid_r <= 1'b0;
                    end
                end
                ST_DATA: begin
                    // Wraps after beat 256; wlast was already taken on the final beat
                    if (ready_s) begin
                        counter_r <= counter_r + LEN_W'(1);
                    end
                end
                ST_RESP: begin
                    if (axi.m_axi_bvalid) begin
                        error_r     <= (axi.m_axi_bresp != {`AXI_RESP_W{1'b0}});
                        dma_ready_r <= 1'b1;
                    end
                end
                default: begin
                    awvalid_r <= 1'b0;
                end
            endcase
        end
    end

    // Next-state decode and per-state handshake outputs
    always_comb begin
        state_nxt_s = state_r;
        wvalid_s    = 1'b0;
        wlast_s     = 1'b0;
        ready_s     = 1'b0;
        bready_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (valid) begin
                    state_nxt_s = ST_ADDR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (axi.m_axi_awready) begin
                    state_nxt_s = ST_DATA;
                end else begin
                    state_nxt_s = ST_ADDR;
                end
            end
            ST_DATA: begin
                wvalid_s = valid;
                wlast_s  = (counter_r == len_r);
                ready_s  = valid & axi.m_axi_wready;
                if (ready_s && wlast_s) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_RESP: begin
                bready_s = 1'b1;
                if (axi.m_axi_bvalid) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    assign ready     = ready_s;
    assign dma_ready = dma_ready_r;
    assign error     = error_r;

    assign axi.m_axi_awid    = {`AXI_ID_W{1'b0}};
    assign axi.m_axi_awaddr  = addr_r;
    assign axi.m_axi_awlen   = len_r;
    assign axi.m_axi_awsize  = AXSIZE;
    assign axi.m_axi_awburst = 2'b01;
    assign axi.m_axi_awlock  = 1'b0;
    assign axi.m_axi_awcache = 4'h2;
    assign axi.m_axi_awprot  = 3'b010;
    assign axi.m_axi_awqos   = 4'h0;
    assign axi.m_axi_awvalid = awvalid_r;
    assign axi.m_axi_wdata   = wdata;
    assign axi.m_axi_wstrb   = wstrb;
    assign axi.m_axi_wlast   = wlast_s;
    assign axi.m_axi_wvalid  = wvalid_s;
    assign axi.m_axi_bready  = bready_s;
endmodule
